// File: rtl/imem_boot_pkg.sv
// Shared types for the IM boot loader: FSM state encoding and default IM size.
package imem_boot_pkg;

  localparam int IM_DEPTH_DEFAULT = 64;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    HOLD = ST_HOLD,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } boot_state_e;

endpackage

// File: rtl/boot_hold_timer.sv
// Down-counter that keeps the CPU in reset for HOLD_CYCLES after the last IM write.
module boot_hold_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_W'(HOLD_CYCLES);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams instruction words into consecutive IM addresses while holding the CPU in reset,
// then releases it after a settle delay.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int IM_DEPTH    = IM_DEPTH_DEFAULT,
  parameter int LEN_W       = 7,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_write,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(IM_DEPTH);

  boot_state_e       state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  idx_reg;
  logic [ADDR_W:0]   end_addr;
  logic              idle_like;
  logic              start_ok;
  logic              handshake;
  logic              last_word;
  logic              hold_load;
  logic              hold_expired;

  // Range check one bit wider than the address so a huge base cannot wrap into range.
  assign end_addr  = {1'b0, base_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, length};
  assign idle_like = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR);
  assign start_ok  = start && !abort && idle_like;
  assign handshake = (state_reg == LOAD) && in_valid && !abort;
  assign last_word = (idx_reg == (len_reg - LEN_W'(1)));
  assign hold_load = (state_next == HOLD) && (state_reg != HOLD);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          if (end_addr > DEPTH_LIMIT) state_next = ERR;
          else if (length == '0)      state_next = HOLD;
          else                        state_next = LOAD;
        end
      end
      LOAD: begin
        if (abort)                       state_next = IDLE;
        else if (handshake && last_word) state_next = HOLD;
      end
      HOLD: begin
        if (abort)             state_next = IDLE;
        else if (hold_expired) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      im_write  <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
    end else begin
      state_reg <= state_next;
      im_write  <= handshake;
      if (handshake) begin
        im_addr  <= base_reg + ADDR_W'(idx_reg);
        im_wdata <= in_data;
        idx_reg  <= idx_reg + LEN_W'(1);
      end
      if (start_ok && (state_next == LOAD)) begin
        base_reg <= base_addr;
        len_reg  <= length;
        idx_reg  <= '0;
      end
    end
  end

  boot_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .en     (state_reg == HOLD),
    .expired(hold_expired)
  );

  // Everything but DONE keeps the CPU in reset, including an aborted or failed load.
  assign cpu_hold = (state_reg != DONE);
  assign in_ready = (state_reg == LOAD);
  assign busy     = (state_reg == LOAD) || (state_reg == HOLD);
  assign done     = (state_reg == DONE);
  assign error    = (state_reg == ERR);

endmodule
